// File: rtl/fnd_scan_driver.sv
// Signed binary to double-dabble BCD, formatted and time-multiplexed onto a common-cathode FND.
// Leading-zero blanking is enabled by defining FND_LZB_EN; otherwise digits are zero-padded.
module fnd_scan_driver #(
    parameter int DIGITS   = 6,
    parameter int WIDTH    = 32,
    parameter int SCAN_DIV = 4
) (
    input  logic              fnd_clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  fnd_serial,
    output logic [DIGITS-1:0] fnd_s,
    output logic [7:0]        fnd_d,
    output logic              busy
);
    localparam int NIB = 10;
    localparam int BW  = 4 * NIB;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW  = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [7:0]    SEG_BLANK = 8'h00;
    localparam logic [7:0]    SEG_MINUS = 8'h40;
    localparam logic [7:0]    SEG_E     = 8'h79;
    localparam logic [7:0]    SEG_R     = 8'h50;

    typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       last_q, last_d;
    logic [WIDTH-1:0]       mag_q, mag_d;
    logic                   stale_q, stale_d;
    logic                   neg_q, neg_d;
    logic                   busy_q, busy_d;
    logic [BW-1:0]          bcd_q, bcd_d, adj_s;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DIGITS-1:0][7:0] disp_q, disp_d, fmt_s;
    logic                   ovf_s;
    logic [IW-1:0]          msd_s;
    logic [PW-1:0]          pre_q;
    logic [IW-1:0]          idx_q, idx_nx_s;
    logic [DIGITS-1:0]      sel_q;
    logic [7:0]             seg_q;

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    seg_of = 8'h3F;
            4'd1:    seg_of = 8'h06;
            4'd2:    seg_of = 8'h5B;
            4'd3:    seg_of = 8'h4F;
            4'd4:    seg_of = 8'h66;
            4'd5:    seg_of = 8'h6D;
            4'd6:    seg_of = 8'h7D;
            4'd7:    seg_of = 8'h07;
            4'd8:    seg_of = 8'h7F;
            4'd9:    seg_of = 8'h6F;
            default: seg_of = 8'h00;
        endcase
    endfunction

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        adj_s = bcd_q;
        for (int i = 0; i < NIB; i++) begin
            adj_s[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        end
    end

    // Glyph formatting; a negative value needs one spare position for the minus sign.
    always_comb begin
        ovf_s = neg_q && (bcd_q[4*(DIGITS-1) +: 4] != 4'd0);
        for (int i = DIGITS; i < NIB; i++) begin
            ovf_s = ovf_s || (bcd_q[4*i +: 4] != 4'd0);
        end
        msd_s = '0;
        for (int i = 1; i < DIGITS; i++) begin
            msd_s = (bcd_q[4*i +: 4] != 4'd0) ? IW'(i) : msd_s;
        end
        fmt_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_s) begin
                fmt_s[i] = (i < 2) ? SEG_R : ((i == 2) ? SEG_E : SEG_BLANK);
            end else begin
`ifdef FND_LZB_EN
                fmt_s[i] = (IW'(i) <= msd_s) ? seg_of(bcd_q[4*i +: 4]) :
                           ((neg_q && (IW'(i) == msd_s + IW'(1))) ? SEG_MINUS : SEG_BLANK);
`else
                fmt_s[i] = (neg_q && (i == DIGITS - 1)) ? SEG_MINUS : seg_of(bcd_q[4*i +: 4]);
`endif
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        stale_d = stale_q;
        neg_d   = neg_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        case (state_q)
            IDLE: begin
                if (stale_q || (fnd_serial != last_q)) begin
                    last_d  = fnd_serial;
                    neg_d   = fnd_serial[WIDTH-1];
                    mag_d   = fnd_serial[WIDTH-1] ? (~fnd_serial + WIDTH'(1)) : fnd_serial;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    stale_d = 1'b0;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                bcd_d = {adj_s[BW-2:0], mag_q[WIDTH-1]};
                mag_d = {mag_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = CONV;
                end
            end
            DONE: begin
                disp_d  = fmt_s;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge fnd_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= '0;
            stale_q <= 1'b1;
            neg_q   <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            stale_q <= stale_d;
            neg_q   <= neg_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
        end
    end

    assign idx_nx_s = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    // Select and glyph are reloaded together only at slot boundaries, so a slot never tears.
    always_ff @(posedge fnd_clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
            sel_q <= '1;
            seg_q <= SEG_BLANK;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            idx_q <= idx_nx_s;
            sel_q <= ~(DIGITS'(1) << idx_nx_s);
            seg_q <= disp_q[idx_nx_s];
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    assign fnd_s = sel_q;
    assign fnd_d = seg_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_fnd_scan_driver.sv
// Self-checking bench for fnd_scan_driver: directed and random values checked against a decimal model.
module tb_fnd_scan_driver;
    localparam int DIGITS   = 6;
    localparam int WIDTH    = 32;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic              fnd_clk = 1'b0;
    logic              rst;
    logic [WIDTH-1:0]  fnd_serial;
    logic [DIGITS-1:0] fnd_s;
    logic [7:0]        fnd_d;
    logic              busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] want [DIGITS];

    always #5 fnd_clk = ~fnd_clk;

    fnd_scan_driver #(.DIGITS(DIGITS), .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
        .fnd_clk    (fnd_clk),
        .rst        (rst),
        .fnd_serial (fnd_serial),
        .fnd_s      (fnd_s),
        .fnd_d      (fnd_d),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] glyph(input int d);
        case (d)
            0: glyph = 8'h3F;  1: glyph = 8'h06;  2: glyph = 8'h5B;  3: glyph = 8'h4F;
            4: glyph = 8'h66;  5: glyph = 8'h6D;  6: glyph = 8'h7D;  7: glyph = 8'h07;
            8: glyph = 8'h7F;  9: glyph = 8'h6F;
            default: glyph = 8'h00;
        endcase
    endfunction

    // Reference: decimal digits by division, then the display rules applied directly.
    task automatic model(input logic [WIDTH-1:0] v);
        longint mag, lim, p;
        bit     neg;
        int     nd [DIGITS];
        int     top;
        neg = v[WIDTH-1];
        mag = neg ? ((longint'(1) << WIDTH) - longint'(v)) : longint'(v);
        lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        for (int i = 0; i < DIGITS; i++) want[i] = 8'h00;
        if (mag >= lim || (neg && mag >= lim / 10)) begin
            want[2] = 8'h79; want[1] = 8'h50; want[0] = 8'h50;
        end else begin
            p = 1;
            top = 0;
            for (int i = 0; i < DIGITS; i++) begin
                nd[i] = int'((mag / p) % 10);
                if (nd[i] != 0) top = i;
                p = p * 10;
            end
`ifdef FND_LZB_EN
            for (int i = 0; i <= top; i++) want[i] = glyph(nd[i]);
            if (neg) want[top + 1] = 8'h40;
`else
            for (int i = 0; i < DIGITS; i++) want[i] = glyph(nd[i]);
            if (neg) want[DIGITS - 1] = 8'h40;
`endif
        end
    endtask

    // Called just after the sampling edge; measures one busy pulse, optionally changing the input mid-way.
    task automatic pulse(input string tag, input int change_at, input logic [WIDTH-1:0] nv);
        int n = 0;
        check({tag, " busy_rise"}, 32'(busy), 32'd1);
        while (busy && n < 100) begin
            n++;
            if (n == change_at) fnd_serial = nv;
            @(posedge fnd_clk);
            #1;
        end
        check({tag, " busy_len"}, n, WIDTH + 1);
    endtask

    // Watches two full frames and compares the captured glyph of every digit with the model.
    task automatic observe(input string tag);
        logic [7:0]        seen [DIGITS];
        logic [DIGITS-1:0] prev_s;
        int                last_t, ntr, zeros;
        bit                slot_ok, cold_ok;
        for (int i = 0; i < DIGITS; i++) seen[i] = 8'hXX;
        slot_ok = 1'b1; cold_ok = 1'b1; last_t = -1; ntr = 0;
        @(negedge fnd_clk);
        prev_s = fnd_s;
        for (int c = 0; c < 2 * FRAME + 1; c++) begin
            @(negedge fnd_clk);
            if (fnd_s != prev_s) begin
                if (last_t >= 0 && (c - last_t) != SCAN_DIV) slot_ok = 1'b0;
                last_t = c;
                ntr++;
                prev_s = fnd_s;
            end
            zeros = 0;
            for (int i = 0; i < DIGITS; i++) begin
                if (fnd_s[i] == 1'b0) begin
                    zeros++;
                    seen[i] = fnd_d;
                end
            end
            if (zeros != 1) cold_ok = 1'b0;
        end
        check({tag, " slot_len"}, 32'(slot_ok && ntr >= 2 * DIGITS), 32'd1);
        check({tag, " one_cold"}, 32'(cold_ok), 32'd1);
        for (int i = 0; i < DIGITS; i++) begin
            check($sformatf("%s digit%0d", tag, i), 32'(seen[i]), 32'(want[i]));
        end
    endtask

    task automatic convert(input string tag, input logic [WIDTH-1:0] v);
        @(negedge fnd_clk);
        fnd_serial = v;
        @(posedge fnd_clk);
        #1;
        pulse(tag, -1, '0);
        model(v);
        observe(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] r;
        rst = 1'b1;
        fnd_serial = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge fnd_clk);
            #1;
            check("rst fnd_s", 32'(fnd_s), 32'h3F);
            check("rst fnd_d", 32'(fnd_d), 32'h00);
            check("rst busy", 32'(busy), 32'd0);
        end
        @(negedge fnd_clk);
        rst = 1'b0;
        @(posedge fnd_clk);
        #1;
        pulse("first", -1, '0);
        model('0);
        observe("first");

        convert("p123456", 32'd123456);
        convert("n12345", -32'sd12345);
        convert("n7", -32'sd7);
        convert("p999999", 32'd999999);
        convert("n99999", -32'sd99999);
        convert("p1000000", 32'd1000000);
        convert("n100000", -32'sd100000);
        convert("nmin", 32'h8000_0000);

        @(negedge fnd_clk);
        fnd_serial = 32'd42;
        @(posedge fnd_clk);
        #1;
        pulse("mid42", 10, 32'd77);
        @(posedge fnd_clk);
        #1;
        pulse("mid77", -1, '0);
        model(32'd77);
        observe("mid77");

        convert("seven", 32'd7);
        @(negedge fnd_clk);
        fnd_serial = '0;
        repeat (6) @(posedge fnd_clk);
        @(negedge fnd_clk);
        rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort fnd_d", 32'(fnd_d), 32'h00);
        check("abort fnd_s", 32'(fnd_s), 32'h3F);
        repeat (2) @(negedge fnd_clk);
        rst = 1'b0;
        @(posedge fnd_clk);
        #1;
        pulse("stale", -1, '0);
        model('0);
        observe("stale");

        for (int k = 0; k < 12; k++) begin
            case (k % 3)
                0:       r = $urandom;
                1:       r = 32'($urandom_range(0, 999999));
                default: r = -32'($urandom_range(1, 99999));
            endcase
            if (r == fnd_serial) r = r + 32'd1;
            convert($sformatf("rand%0d", k), r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fnd_scan_driver.md
# fnd_scan_driver

Parametrised successor to the calculator's segment driver. Takes a signed binary value on `fnd_serial`, converts it to decimal with a sequential double-dabble engine, and formats it as sign, digits or "Err". It then time-multiplexes the result onto a DIGITS-wide common-cathode FND. Sits between `calculate` and the board FND pins, clocked by `fnd_clk` from `clock_divider`.

## Interface
Parameters:
- `DIGITS`, default 6: number of FND positions, range 2–8.
- `WIDTH`, default 32: width of `fnd_serial`, range 4–32.
- `SCAN_DIV`, default 4: `fnd_clk` cycles per digit slot, minimum 1.

Ports:
- `fnd_clk` (input, 1): the single clock.
- `rst` (input, 1): asynchronous, active-high reset.
- `fnd_serial` (input, WIDTH): signed two's-complement value to display.
- `fnd_s` (output, DIGITS): digit select, one-cold. Bit 0 is the rightmost digit.
- `fnd_d` (output, 8): segment anodes, active-high, ordered {dp,g,f,e,d,c,b,a}. dp is always 0.
- `busy` (output, 1): high while a conversion is in progress.

## Operation
- Glyphs:
  - Digits 0–9 are 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - Minus is 40, E is 79, r is 50, blank is 00.
- Internal state:
  - `last` is a WIDTH-bit register holding the last sampled value.
  - `stale` is a flag, set by reset.
  - `disp` holds DIGITS glyph registers and is the only source for `fnd_d`.
- FSM, with states IDLE, CONV and DONE:
  - **IDLE.** If `stale` is set or `fnd_serial != last`:
    - latch `fnd_serial` into `last` and the sign bit into `neg`;
    - load the magnitude register with |`fnd_serial`| as WIDTH-bit unsigned, so -2^(WIDTH-1) converts correctly;
    - clear the BCD register (10 nibbles) and `stale`;
    - go to CONV.
  - **CONV.** Exactly WIDTH cycles. Each cycle adds 3 to every nibble ≥5, then shifts the BCD and magnitude registers left by 1. Then go to DONE.
  - **DONE.** One cycle. Format into `disp`, then go to IDLE.
- `fnd_serial` changes while the FSM is in CONV or DONE are ignored. They are picked up by the compare on the next IDLE cycle.
- Overflow: any nonzero nibble at index ≥ DIGITS, or `neg` with nibble DIGITS-1 nonzero. Result is "Err" in digits 2..0 (79,50,50); all other digits blank.
- Normal formatting:
  - Digit i shows nibble i.
  - Leading zeros are blanked, but digit 0 always shows, so value 0 displays as "0".
  - If `neg`, minus is placed in the digit immediately left of the most significant nonzero digit.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. On wrap, the digit index advances modulo DIGITS.
  - `fnd_s[idx]`=0 and all other bits are 1; `fnd_d`=`disp[idx]`.
  - Both outputs are registered.
  - The scan runs continuously and independently of the FSM.

## Timing
- Reset values:
  - `fnd_s` all ones, `fnd_d`=00, `busy`=0.
  - `disp` all blank, `last`=0, `stale`=1.
  - FSM in IDLE; prescaler and digit index 0.
- Reset is asynchronous. Asserting it mid-conversion aborts the conversion and `disp` returns to blank.
- Conversion latency:
  - Let edge S be the IDLE edge that samples the value.
  - `busy` rises after S and stays high for WIDTH+1 cycles (CONV plus DONE).
  - `disp` is updated at edge S+WIDTH+1.
  - The new glyph reaches `fnd_d` at the first scan update of that digit after the update.
- Back-to-back input changes produce at most one conversion per WIDTH+2 cycles. The final display always matches the last stable value.
- Scan timing:
  - Each digit is selected for SCAN_DIV cycles.
  - The full frame is DIGITS×SCAN_DIV cycles.
  - `fnd_s` and `fnd_d` change on the same edge, so there is no ghosting cycle.
- Simultaneous events: a `disp` update coinciding with a digit advance shows the new `disp` on the following output update. There is no tearing within a digit slot.

## Configuration
- `FND_LZB_EN` defined (leading-zero blanking): formatting is as described in Operation.
- `FND_LZB_EN` undefined:
  - All DIGITS positions show digits, zero-padded.
  - If `neg`, the leftmost digit shows minus instead of nibble DIGITS-1.
  - The overflow rule is unchanged.

## Test plan
All scenarios use DIGITS=6, WIDTH=32, SCAN_DIV=4, with `FND_LZB_EN` defined.
1. **Reset and first conversion.** Hold `rst` 3 cycles with `fnd_serial`=0.
   - During reset: `fnd_s`=111111, `fnd_d`=00, `busy`=0.
   - After release: `busy` high for 33 cycles, then digit 0 shows 3F and digits 1–5 show 00.
2. **Positive value.** `fnd_serial`=123456.
   - Digits 0..5 show 7D,6D,66,4F,5B,06.
   - Each `fnd_s` slot lasts 4 cycles; the frame is 24 cycles.
3. **Negative value and blanking.** `fnd_serial`=-12345 shows digits 0..5 as 6D,66,4F,5B,06,40. `fnd_serial`=-7 shows 07,40,00,00,00,00.
4. **Overflow boundaries.**
   - 999999 and -99999 display normally.
   - 1000000, -100000 and -2147483648 each display 50,50,79,00,00,00.
5. **Mid-conversion input change.** Change `fnd_serial` 42→77 10 cycles into the 42 conversion.
   - 42 completes first.
   - A second `busy` pulse of 33 cycles follows.
   - Final display is 07,07 in digits 0,1.
6. **Reset mid-conversion.** Assert `rst` during CONV.
   - `disp` goes blank and `busy`=0 immediately.
   - After release the current value is reconverted because `stale`=1.
